branch_flush_ctrl: RTL and testbench

- Parametrised control-hazard unit for the MIPS pipeline front end.
- Detects control-transfer opcodes in decode (beq, bne, j, jal) and holds fetch for a configurable resolve latency.
- Forces NOP (all-zero) into a selectable set of NSLOT pipeline-register slots, with optional branch-delay-slot mode.
- Keeps a saturating stall-cycle counter. Sits between the IF/ID and ID/EX registers and the PC-enable logic.

---
 rtl/branch_flush_ctrl_if.sv | 25 ++
 rtl/branch_flush_ctrl.sv | 113 +++++++++++
 tb/tb_branch_flush_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_flush_ctrl_if.sv
// Front-end hazard bus between decode and the flush controller.
// The master drives the decoded opcode and slot contents. The slave returns the squashed slots, the fetch enable and status.
interface branch_flush_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int NSLOT  = 2,
  parameter int STAT_W = 16
);
  logic                   id_valid;
  logic [5:0]             id_op;
  logic [NSLOT*WIDTH-1:0] slot_in;
  logic [NSLOT*WIDTH-1:0] slot_out;
  logic                   fetch_en;
  logic                   busy;
  logic [STAT_W-1:0]      stall_cycles;

  modport master (
    output id_valid, id_op, slot_in,
    input  slot_out, fetch_en, busy, stall_cycles
  );

  modport slave (
    input  id_valid, id_op, slot_in,
    output slot_out, fetch_en, busy, stall_cycles
  );
endinterface

// File: rtl/branch_flush_ctrl.sv
// Control-hazard unit. It holds fetch for a fixed number of cycles after a branch or jump is seen in decode.
// While fetch is held, it forces NOPs into the selected pipeline-register slots.
module branch_flush_ctrl #(
  parameter int               WIDTH      = 32,
  parameter int               NSLOT      = 2,
  parameter logic [NSLOT-1:0] HOLD_MASK  = 2'b01,
  parameter int               BR_LAT     = 3,
  parameter int               J_LAT      = 1,
  parameter int               DELAY_SLOT = 0,
  parameter int               STAT_W     = 16
) (
  input logic               clk,
  input logic               rst,
  branch_flush_ctrl_if.slave bus
);

  localparam logic [3:0] BR_CNT = 4'(BR_LAT);
  localparam logic [3:0] J_CNT  = 4'(J_LAT);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RECOVER
  } state_t;

  state_t                 state, state_nx;
  logic [3:0]             cnt, cnt_nx;
  logic                   fetch_q, fetch_nx;
  logic [NSLOT*WIDTH-1:0] slot_q, slot_nx;
  logic [STAT_W-1:0]      stall_q, stall_nx;
  logic [NSLOT*WIDTH-1:0] hold_keep, detect_keep;
  logic                   is_br, is_j, detect;

  assign is_br  = (bus.id_op == 6'b000100) || (bus.id_op == 6'b000101);
  assign is_j   = (bus.id_op == 6'b000010) || (bus.id_op == 6'b000011);
  assign detect = bus.id_valid && (is_br || is_j);

  // AND-masks that clear the squashed slots; the detect edge spares slot 0 in delay-slot mode
  always_comb begin
    hold_keep   = '1;
    detect_keep = '1;
    for (int k = 0; k < NSLOT; k++) begin
      if (HOLD_MASK[k]) begin
        hold_keep[k*WIDTH +: WIDTH] = '0;
        if (!(k == 0 && DELAY_SLOT != 0))
          detect_keep[k*WIDTH +: WIDTH] = '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fetch_nx = fetch_q;
    slot_nx  = bus.slot_in;
    stall_nx = stall_q;
    case (state)
      IDLE: begin
        if (detect) begin
          state_nx = HOLD;
          cnt_nx   = is_br ? BR_CNT : J_CNT;
          fetch_nx = 1'b0;
          slot_nx  = bus.slot_in & detect_keep;
        end else begin
          fetch_nx = 1'b1;
        end
      end
      HOLD: begin
        fetch_nx = 1'b0;
        slot_nx  = bus.slot_in & hold_keep;
        if (stall_q != '1)
          stall_nx = stall_q + 1'b1;
        if (cnt == 4'd1) begin
          state_nx = RECOVER;
          fetch_nx = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RECOVER: begin
        // The NOP registered on the last HOLD edge covers the wrong-path fetch; pass-through resumes here
        fetch_nx = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        fetch_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      fetch_q <= 1'b1;
      slot_q  <= '0;
      stall_q <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      fetch_q <= fetch_nx;
      slot_q  <= slot_nx;
      stall_q <= stall_nx;
    end
  end

  assign bus.slot_out     = slot_q;
  assign bus.fetch_en     = fetch_q;
  assign bus.busy         = (state != IDLE);
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Bench for branch_flush_ctrl. It runs three configurations side by side against a per-edge reference model.
// The three configurations are: the defaults, delay-slot mode with both slots masked, and a 2-bit saturating counter.
module tb_branch_flush_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [63:0] slot_in;

  int checks = 0;
  int errors = 0;

  branch_flush_ctrl_if #(.WIDTH(32), .NSLOT(2), .STAT_W(16)) bus0 ();
  branch_flush_ctrl_if #(.WIDTH(32), .NSLOT(2), .STAT_W(16)) bus1 ();
  branch_flush_ctrl_if #(.WIDTH(32), .NSLOT(2), .STAT_W(2))  bus2 ();

  assign bus0.id_valid = id_valid;
  assign bus0.id_op    = id_op;
  assign bus0.slot_in  = slot_in;
  assign bus1.id_valid = id_valid;
  assign bus1.id_op    = id_op;
  assign bus1.slot_in  = slot_in;
  assign bus2.id_valid = id_valid;
  assign bus2.id_op    = id_op;
  assign bus2.slot_in  = slot_in;

  branch_flush_ctrl dut0 (.clk(clk), .rst(rst), .bus(bus0));
  branch_flush_ctrl #(.HOLD_MASK(2'b11), .DELAY_SLOT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  branch_flush_ctrl #(.STAT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] p_mask [3] = '{2'b01, 2'b11, 2'b01};
  bit         p_ds   [3] = '{1'b0, 1'b1, 1'b0};
  int         p_max  [3] = '{65535, 65535, 3};

  // Model tracks each sequence by its edge offset k from the detect edge and its latency L
  bit          m_active [3];
  int          m_k      [3];
  int          m_lat    [3];
  bit          m_fetch  [3];
  bit          m_busy   [3];
  logic [31:0] m_s0     [3];
  logic [31:0] m_s1     [3];
  int          m_stall  [3];

  function automatic int opLatency(input logic [5:0] op);
    case (op)
      6'b000100, 6'b000101: return 3;
      6'b000010, 6'b000011: return 1;
      default:              return 0;
    endcase
  endfunction

  task automatic modelStep(input int i);
    logic [31:0] s0, s1;
    int lat;
    s0  = slot_in[31:0];
    s1  = slot_in[63:32];
    lat = opLatency(id_op);
    if (rst) begin
      m_active[i] = 0; m_fetch[i] = 1; m_busy[i] = 0;
      m_s0[i] = '0; m_s1[i] = '0; m_stall[i] = 0;
    end else if (m_active[i]) begin
      m_k[i]++;
      if (m_k[i] <= m_lat[i]) begin
        m_s0[i] = p_mask[i][0] ? 32'h0 : s0;
        m_s1[i] = p_mask[i][1] ? 32'h0 : s1;
        if (m_stall[i] < p_max[i]) m_stall[i]++;
      end else begin
        m_s0[i] = s0;
        m_s1[i] = s1;
      end
      m_fetch[i] = (m_k[i] >= m_lat[i]);
      if (m_k[i] > m_lat[i]) m_active[i] = 0;
      m_busy[i] = m_active[i];
    end else if (id_valid && lat > 0) begin
      m_active[i] = 1; m_k[i] = 0; m_lat[i] = lat;
      m_fetch[i] = 0; m_busy[i] = 1;
      m_s0[i] = (p_mask[i][0] && !p_ds[i]) ? 32'h0 : s0;
      m_s1[i] = p_mask[i][1] ? 32'h0 : s1;
    end else begin
      m_s0[i] = s0; m_s1[i] = s1; m_fetch[i] = 1; m_busy[i] = 0;
    end
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    cmp("dut0 fetch_en", 64'(bus0.fetch_en), 64'(m_fetch[0]));
    cmp("dut0 busy", 64'(bus0.busy), 64'(m_busy[0]));
    cmp("dut0 slot_out", bus0.slot_out, {m_s1[0], m_s0[0]});
    cmp("dut0 stall_cycles", 64'(bus0.stall_cycles), 64'(m_stall[0]));
    cmp("dut1 fetch_en", 64'(bus1.fetch_en), 64'(m_fetch[1]));
    cmp("dut1 busy", 64'(bus1.busy), 64'(m_busy[1]));
    cmp("dut1 slot_out", bus1.slot_out, {m_s1[1], m_s0[1]});
    cmp("dut1 stall_cycles", 64'(bus1.stall_cycles), 64'(m_stall[1]));
    cmp("dut2 fetch_en", 64'(bus2.fetch_en), 64'(m_fetch[2]));
    cmp("dut2 busy", 64'(bus2.busy), 64'(m_busy[2]));
    cmp("dut2 slot_out", bus2.slot_out, {m_s1[2], m_s0[2]});
    cmp("dut2 stall_cycles", 64'(bus2.stall_cycles), 64'(m_stall[2]));
  endtask

  // Inputs change on the falling edge; outputs are sampled one falling edge after the rising edge
  task automatic applyStimulus(input logic r, input logic v, input logic [5:0] op,
                               input logic [31:0] s0, input logic [31:0] s1);
    rst      = r;
    id_valid = v;
    id_op    = op;
    slot_in  = {s1, s0};
    for (int i = 0; i < 3; i++) modelStep(i);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  typedef struct {
    logic        r, v;
    logic [5:0]  op;
    logic [31:0] in0, in1;
    logic        fetch, busy;
    logic [31:0] out0, out1;
    int          stall;
  } vec_t;

  vec_t vq[$];

  task automatic mk(input logic r, input logic v, input logic [5:0] op,
                    input logic [31:0] in0, input logic [31:0] in1,
                    input logic fetch, input logic busy,
                    input logic [31:0] out0, input logic [31:0] out1, input int stall);
    vec_t t;
    t.r = r; t.v = v; t.op = op; t.in0 = in0; t.in1 = in1;
    t.fetch = fetch; t.busy = busy; t.out0 = out0; t.out1 = out1; t.stall = stall;
    vq.push_back(t);
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_op = '0; slot_in = '0;

    // Expected values refer to the default configuration (dut0)
    mk(1, 0, 6'd0,      32'h0,         32'h0,         1, 0, 32'h0,         32'h0,         0);
    mk(1, 0, 6'd0,      32'h0,         32'h0,         1, 0, 32'h0,         32'h0,         0);
    mk(0, 0, 6'd0,      32'h2222_2222, 32'h1111_1111, 1, 0, 32'h2222_2222, 32'h1111_1111, 0);
    mk(0, 1, 6'b000100, 32'hA000_0001, 32'hB000_0001, 0, 1, 32'h0,         32'hB000_0001, 0);
    mk(0, 0, 6'd0,      32'hA000_0002, 32'hB000_0002, 0, 1, 32'h0,         32'hB000_0002, 1);
    mk(0, 0, 6'd0,      32'hA000_0003, 32'hB000_0003, 0, 1, 32'h0,         32'hB000_0003, 2);
    mk(0, 0, 6'd0,      32'hA000_0004, 32'hB000_0004, 1, 1, 32'h0,         32'hB000_0004, 3);
    mk(0, 0, 6'd0,      32'hA000_0005, 32'hB000_0005, 1, 0, 32'hA000_0005, 32'hB000_0005, 3);
    mk(0, 1, 6'b000010, 32'hA000_0006, 32'hB000_0006, 0, 1, 32'h0,         32'hB000_0006, 3);
    mk(0, 1, 6'b000011, 32'hA000_0007, 32'hB000_0007, 1, 1, 32'h0,         32'hB000_0007, 4);
    mk(0, 1, 6'b000100, 32'hA000_0008, 32'hB000_0008, 1, 0, 32'hA000_0008, 32'hB000_0008, 4);
    mk(0, 1, 6'b000100, 32'hA000_0009, 32'hB000_0009, 0, 1, 32'h0,         32'hB000_0009, 4);
    mk(0, 1, 6'b000011, 32'hA000_000A, 32'hB000_000A, 0, 1, 32'h0,         32'hB000_000A, 5);
    mk(0, 0, 6'd0,      32'hA000_000B, 32'hB000_000B, 0, 1, 32'h0,         32'hB000_000B, 6);
    mk(0, 0, 6'd0,      32'hA000_000C, 32'hB000_000C, 1, 1, 32'h0,         32'hB000_000C, 7);
    mk(0, 0, 6'd0,      32'hA000_000D, 32'hB000_000D, 1, 0, 32'hA000_000D, 32'hB000_000D, 7);
    mk(0, 1, 6'b100011, 32'hA000_000E, 32'hB000_000E, 1, 0, 32'hA000_000E, 32'hB000_000E, 7);
    mk(0, 1, 6'b000100, 32'hA000_000F, 32'hB000_000F, 0, 1, 32'h0,         32'hB000_000F, 7);
    mk(0, 0, 6'd0,      32'hA000_0010, 32'hB000_0010, 0, 1, 32'h0,         32'hB000_0010, 8);
    mk(1, 0, 6'd0,      32'hC000_0001, 32'hD000_0001, 1, 0, 32'h0,         32'h0,         0);
    mk(0, 0, 6'd0,      32'hC000_0002, 32'hD000_0002, 1, 0, 32'hC000_0002, 32'hD000_0002, 0);

    @(negedge clk);
    for (int n = 0; n < vq.size(); n++) begin
      applyStimulus(vq[n].r, vq[n].v, vq[n].op, vq[n].in0, vq[n].in1);
      cmp($sformatf("vec%0d fetch_en", n), 64'(bus0.fetch_en), 64'(vq[n].fetch));
      cmp($sformatf("vec%0d busy", n), 64'(bus0.busy), 64'(vq[n].busy));
      cmp($sformatf("vec%0d slot_out", n), bus0.slot_out, {vq[n].out1, vq[n].out0});
      cmp($sformatf("vec%0d stall_cycles", n), 64'(bus0.stall_cycles), 64'(vq[n].stall));
    end

    // Delay-slot mode: slot 0 survives the detect edge, then both slots are NOP for three edges
    applyStimulus(1, 0, 6'd0, 32'h0, 32'h0);
    applyStimulus(0, 1, 6'b000101, 32'hDEAD_BEEF, 32'h1234_5678);
    cmp("ds detect slot0", 64'(bus1.slot_out[31:0]), 64'h0000_0000_DEAD_BEEF);
    cmp("ds detect slot1", 64'(bus1.slot_out[63:32]), 64'h0);
    for (int e = 1; e <= 3; e++) begin
      applyStimulus(0, 0, 6'd0, $urandom, $urandom);
      cmp($sformatf("ds hold slots E%0d", e), bus1.slot_out, 64'h0);
    end
    cmp("ds stall_cycles", 64'(bus1.stall_cycles), 64'd3);

    // Three beq sequences: 9 stall cycles total, the 2-bit counter pins at 3
    applyStimulus(1, 0, 6'd0, 32'h0, 32'h0);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(0, 1, 6'b000100, $urandom, $urandom);
      for (int e = 0; e < 4; e++) applyStimulus(0, 0, 6'd0, $urandom, $urandom);
    end
    cmp("sat stall_cycles w2", 64'(bus2.stall_cycles), 64'd3);
    cmp("sat stall_cycles w16", 64'(bus0.stall_cycles), 64'd9);

    // Random traffic biased towards control ops, with occasional resets
    for (int n = 0; n < 600; n++) begin
      logic       r, v;
      logic [5:0] op;
      int         pick;
      r    = ($urandom_range(0, 49) == 0);
      v    = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 7);
      case (pick)
        0:       op = 6'b000100;
        1:       op = 6'b000101;
        2:       op = 6'b000010;
        3:       op = 6'b000011;
        default: op = 6'($urandom);
      endcase
      applyStimulus(r, v, op, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
